// File: rtl/bcd_seq_ctrl_if.sv
// Handshake and operand/result bundle between a requester and the BCD sequencer.
// The requester (master) drives start/cin/a/b; the sequencer (slave) drives status and result.
interface bcd_seq_ctrl_if #(
  parameter int DIGITS = 2
);
  logic                  start;
  logic                  cin;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  ready;
  logic                  done;
  logic                  err;
  logic                  ld;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;

  modport master (
    output start, cin, a, b,
    input  ready, done, err, ld, sum, cout
  );

  modport slave (
    input  start, cin, a, b,
    output ready, done, err, ld, sum, cout
  );
endinterface

// File: rtl/bcd_seq_ctrl.sv
// Digit-serial BCD adder sequencer: validates both operands, then adds one
// decimal digit per clock with +6 correction and publishes sum/carry on completion.
module bcd_seq_ctrl #(
  parameter int DIGITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  bcd_seq_ctrl_if.slave     bus
);

  localparam int W  = 4 * DIGITS;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, ADD, DONE} state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k;
  logic            carry;
  logic [W-1:0]    a_q, b_q, shadow, shadow_nxt;
  logic            cin_q;
  logic [W-1:0]    sum_q;
  logic            cout_q, err_q;
  logic [W-1:0]    a_sh, b_sh;
  logic [4:0]      digit_res;
  logic            last_digit;
  logic            bad_operand;
  logic            ready_c, done_c, ld_c;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Returns {carry_out, corrected_digit}.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] x, input logic [3:0] y,
                                               input logic ci);
    logic [4:0] t;
    t = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
    if (t > 5'd9) return {1'b1, t[3:0] + 4'd6};
    else          return {1'b0, t[3:0]};
  endfunction

  always_comb begin
    a_sh        = a_q >> {k, 2'b00};
    b_sh        = b_q >> {k, 2'b00};
    digit_res   = bcd_digit_add(a_sh[3:0], b_sh[3:0], carry);
    last_digit  = (k == KW'(DIGITS - 1));
    bad_operand = has_bad_digit(a_q) | has_bad_digit(b_q);
    shadow_nxt  = shadow;
    for (int i = 0; i < DIGITS; i++) begin
      if (k == KW'(i)) shadow_nxt[4*i +: 4] = digit_res[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    done_c    = 1'b0;
    ld_c      = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) state_nxt = CHECK;
      end
      CHECK:   state_nxt = bad_operand ? DONE : ADD;
      ADD:     if (last_digit) state_nxt = DONE;
      DONE: begin
        done_c    = 1'b1;
        ld_c      = ~err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and published results: cleared by reset, updated only at completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k      <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) k <= '0;
        CHECK: begin
          if (bad_operand) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b1;
          end else begin
            carry <= cin_q;
          end
        end
        ADD: begin
          carry <= digit_res[4];
          if (last_digit) begin
            k      <= '0;
            sum_q  <= shadow_nxt;
            cout_q <= digit_res[4];
            err_q  <= 1'b0;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand copies and the working sum carry no reset; they are always rewritten before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      cin_q <= bus.cin;
    end
    if (state == ADD) shadow <= shadow_nxt;
  end

  assign bus.ready = ready_c;
  assign bus.done  = done_c;
  assign bus.ld    = ld_c;
  assign bus.err   = err_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Randomized self-checking bench for bcd_seq_ctrl against a decimal-arithmetic model.
module tb_bcd_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bcd_seq_ctrl_if #(.DIGITS(2)) b2 ();
  bcd_seq_ctrl_if #(.DIGITS(4)) b4 ();

  bcd_seq_ctrl #(.DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  bcd_seq_ctrl #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

  // Reference: {err, cout, sum} from plain decimal arithmetic on the operand values.
  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input int d);
    int av, bv, p, s, na, nb;
    logic invalid;
    logic [15:0] res;
    av = 0; bv = 0; p = 1; invalid = 1'b0; res = '0;
    for (int i = 0; i < d; i++) begin
      na = int'((a >> (4*i)) & 16'hF);
      nb = int'((b >> (4*i)) & 16'hF);
      if (na > 9 || nb > 9) invalid = 1'b1;
      av = av + na * p;
      bv = bv + nb * p;
      p  = p * 10;
    end
    if (invalid) return {1'b1, 1'b0, 16'h0000};
    s = av + bv + int'(cin);
    for (int i = 0; i < d; i++) begin
      res = res | 16'((s % 10) << (4*i));
      s   = s / 10;
    end
    return {1'b0, (av + bv + int'(cin)) >= p, res};
  endfunction

  function automatic logic [3:0] rand_nibble();
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  task automatic do_op2(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output int lat, output int nd, output int nld,
                        output logic [7:0] s, output logic co, output logic er,
                        output logic held, output logic rdy_busy);
    int w;
    logic [7:0] prev;
    w = 0;
    @(negedge clk);
    while (!b2.ready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) begin
      total++; bad++;
      $display("FAIL op2_ready_timeout got=%0b exp=1", b2.ready);
    end
    b2.a = a; b2.b = b; b2.cin = cin; b2.start = 1'b1;
    prev = b2.sum;
    @(posedge clk); #1;
    b2.start = 1'b0;
    rdy_busy = b2.ready;
    b2.a = 8'($urandom); b2.b = 8'($urandom); b2.cin = 1'($urandom);
    lat = -1; nd = 0; nld = 0; held = 1'b1; s = '0; co = 1'b0; er = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (b2.done) begin
        nd++;
        if (lat < 0) begin lat = c; s = b2.sum; co = b2.cout; er = b2.err; end
      end
      if (b2.ld) nld++;
      if (lat < 0 && b2.sum !== prev) held = 1'b0;
    end
  endtask

  task automatic do_op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        output int lat, output int nd, output int nld,
                        output logic [15:0] s, output logic co, output logic er);
    int w;
    w = 0;
    @(negedge clk);
    while (!b4.ready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) begin
      total++; bad++;
      $display("FAIL op4_ready_timeout got=%0b exp=1", b4.ready);
    end
    b4.a = a; b4.b = b; b4.cin = cin; b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    b4.a = 16'($urandom); b4.b = 16'($urandom);
    lat = -1; nd = 0; nld = 0; s = '0; co = 1'b0; er = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (b4.done) begin
        nd++;
        if (lat < 0) begin lat = c; s = b4.sum; co = b4.cout; er = b4.err; end
      end
      if (b4.ld) nld++;
    end
  endtask

  task automatic test_reset();
    b2.start = 1'b0; b2.cin = 1'b0; b2.a = '0; b2.b = '0;
    b4.start = 1'b0; b4.cin = 1'b0; b4.a = '0; b4.b = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({b2.sum, b2.cout, b2.err, b2.done, b2.ld, b2.ready} !== {8'h00, 5'b00001}) begin
      bad++;
      $display("FAIL reset_state got=%h/%b%b%b%b%b exp=00/00001", b2.sum, b2.cout, b2.err,
               b2.done, b2.ld, b2.ready);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_basic_add();
    int lat, nd, nld; logic [7:0] s; logic co, er, held, rb;
    do_op2(8'h45, 8'h38, 1'b0, lat, nd, nld, s, co, er, held, rb);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    total++;
    if ({s, co, er} !== {8'h83, 2'b00}) begin
      bad++; $display("FAIL basic_result got=%h/%b/%b exp=83/0/0", s, co, er);
    end
    total++;
    if (nd !== 1 || nld !== 1) begin
      bad++; $display("FAIL basic_pulses got=done%0d/ld%0d exp=1/1", nd, nld);
    end
    total++;
    if (rb !== 1'b0 || held !== 1'b1) begin
      bad++; $display("FAIL basic_busy_hold got=ready%b/held%b exp=0/1", rb, held);
    end
  endtask

  task automatic test_carry_chain();
    int lat, nd, nld; logic [7:0] s; logic co, er, held, rb;
    do_op2(8'h99, 8'h99, 1'b1, lat, nd, nld, s, co, er, held, rb);
    total++;
    if ({s, co, er} !== {8'h99, 2'b10}) begin
      bad++; $display("FAIL chain_99 got=%h/%b/%b exp=99/1/0", s, co, er);
    end
    do_op2(8'h50, 8'h50, 1'b0, lat, nd, nld, s, co, er, held, rb);
    total++;
    if ({s, co, er} !== {8'h00, 2'b10}) begin
      bad++; $display("FAIL chain_50 got=%h/%b/%b exp=00/1/0", s, co, er);
    end
  endtask

  task automatic test_invalid();
    int lat, nd, nld; logic [7:0] s; logic co, er, held, rb;
    do_op2(8'h4A, 8'h12, 1'b0, lat, nd, nld, s, co, er, held, rb);
    total++;
    if (lat !== 1 || nd !== 1 || nld !== 0) begin
      bad++; $display("FAIL invalid_timing got=lat%0d/done%0d/ld%0d exp=1/1/0", lat, nd, nld);
    end
    total++;
    if ({s, co, er} !== {8'h00, 2'b01}) begin
      bad++; $display("FAIL invalid_result got=%h/%b/%b exp=00/0/1", s, co, er);
    end
    do_op2(8'h01, 8'h01, 1'b0, lat, nd, nld, s, co, er, held, rb);
    total++;
    if ({s, co, er} !== {8'h02, 2'b00} || nld !== 1) begin
      bad++; $display("FAIL invalid_recover got=%h/%b/%b/ld%0d exp=02/0/0/1", s, co, er, nld);
    end
  endtask

  task automatic test_busy();
    int nd;
    logic [7:0] s;
    @(negedge clk);
    b2.a = 8'h12; b2.b = 8'h34; b2.cin = 1'b0; b2.start = 1'b1;
    @(posedge clk); #1;
    b2.start = 1'b0;
    nd = 0; s = '0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin b2.start = 1'b1; b2.a = 8'h99; b2.b = 8'h99; end
      if (c == 2) begin b2.start = 1'b0; b2.a = 8'h77; b2.b = 8'h55; end
      if (b2.done) begin nd++; s = b2.sum; end
    end
    total++;
    if (s !== 8'h46 || nd !== 1) begin
      bad++; $display("FAIL busy_ignore got=%h/done%0d exp=46/1", s, nd);
    end
  endtask

  task automatic test_back_to_back();
    int times[$];
    @(negedge clk);
    b2.a = 8'h11; b2.b = 8'h22; b2.cin = 1'b0; b2.start = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      @(posedge clk); #1;
      if (b2.done) times.push_back(c);
    end
    @(negedge clk); b2.start = 1'b0;
    repeat (10) @(posedge clk);
    total++;
    if (times.size() !== 4) begin
      bad++; $display("FAIL b2b_count got=%0d exp=4", times.size());
    end
    for (int i = 1; i < times.size(); i++) begin
      total++;
      if (times[i] - times[i-1] !== 5) begin
        bad++; $display("FAIL b2b_period got=%0d exp=5", times[i] - times[i-1]);
      end
    end
    total++;
    if (b2.sum !== 8'h33) begin bad++; $display("FAIL b2b_sum got=%h exp=33", b2.sum); end
  endtask

  task automatic test_reset_mid_op();
    int nd, lat, nld; logic [7:0] s; logic co, er, held, rb;
    @(negedge clk);
    b2.a = 8'h77; b2.b = 8'h88; b2.cin = 1'b0; b2.start = 1'b1;
    @(posedge clk); #1;
    b2.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++;
    if ({b2.sum, b2.cout, b2.err, b2.done, b2.ld, b2.ready} !== {8'h00, 5'b00001}) begin
      bad++;
      $display("FAIL midreset_state got=%h/%b%b%b%b%b exp=00/00001", b2.sum, b2.cout, b2.err,
               b2.done, b2.ld, b2.ready);
    end
    @(negedge clk); @(negedge clk); rst = 1'b1;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (b2.done) nd++;
    end
    total++;
    if (nd !== 0) begin bad++; $display("FAIL midreset_nodone got=%0d exp=0", nd); end
    do_op2(8'h01, 8'h02, 1'b0, lat, nd, nld, s, co, er, held, rb);
    total++;
    if ({s, co, er} !== {8'h03, 2'b00} || lat !== 3) begin
      bad++; $display("FAIL midreset_after got=%h/%b/%b/lat%0d exp=03/0/0/3", s, co, er, lat);
    end
  endtask

  task automatic test_param_sweep();
    int lat, nd, nld; logic [15:0] s; logic co, er;
    logic [15:0] ra, rb16; logic rc; logic [17:0] exp_v;
    do_op4(16'h9999, 16'h0001, 1'b0, lat, nd, nld, s, co, er);
    total++;
    if ({s, co, er} !== {16'h0000, 2'b10} || lat !== 5 || nd !== 1) begin
      bad++; $display("FAIL sweep_9999 got=%h/%b/%b/lat%0d/done%0d exp=0000/1/0/5/1",
                      s, co, er, lat, nd);
    end
    for (int i = 0; i < 6; i++) begin
      ra   = {rand_nibble(), rand_nibble(), rand_nibble(), rand_nibble()};
      rb16 = {rand_nibble(), rand_nibble(), rand_nibble(), rand_nibble()};
      rc   = 1'($urandom);
      exp_v = ref_add(ra, rb16, rc, 4);
      do_op4(ra, rb16, rc, lat, nd, nld, s, co, er);
      total++;
      if ({er, co, s} !== exp_v || lat !== (exp_v[17] ? 1 : 5) || nld !== (exp_v[17] ? 0 : 1)) begin
        bad++; $display("FAIL sweep_rand a=%h b=%h cin=%b got=%b/%b/%h/lat%0d/ld%0d exp=%b/%b/%h",
                        ra, rb16, rc, er, co, s, lat, nld, exp_v[17], exp_v[16], exp_v[15:0]);
      end
    end
  endtask

  task automatic test_random();
    int lat, nd, nld; logic [7:0] s; logic co, er, held, rb;
    logic [7:0] ra, rbv; logic rc; logic [17:0] exp_v;
    for (int i = 0; i < 40; i++) begin
      ra  = {rand_nibble(), rand_nibble()};
      rbv = {rand_nibble(), rand_nibble()};
      rc  = 1'($urandom);
      exp_v = ref_add({8'h00, ra}, {8'h00, rbv}, rc, 2);
      do_op2(ra, rbv, rc, lat, nd, nld, s, co, er, held, rb);
      total++;
      if ({er, co, s} !== {exp_v[17], exp_v[16], exp_v[7:0]} ||
          lat !== (exp_v[17] ? 1 : 3) || nd !== 1 || nld !== (exp_v[17] ? 0 : 1) ||
          held !== 1'b1) begin
        bad++; $display("FAIL rand a=%h b=%h cin=%b got=%b/%b/%h/lat%0d/done%0d/ld%0d/held%b exp=%b/%b/%h",
                        ra, rbv, rc, er, co, s, lat, nd, nld, held,
                        exp_v[17], exp_v[16], exp_v[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_chain();
    test_invalid();
    test_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_param_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
